// File: rtl/module_display_mux.sv
// Scans a latched 3-digit BCD operand plus its operand index onto a 4-digit,
// active-low seven-segment display. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module module_display_mux #(
  parameter int REFRESH_DIV = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] first_num,
  input  logic [11:0] second_num,
  input  logic        show_second,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_t;

  scan_state_t   scan_state;
  scan_state_t   scan_state_nxt;
  logic [CW-1:0] refresh_cnt;
  logic          tick;
  logic [11:0]   shown;
  logic          id;

  // Segment patterns {g,f,e,d,c,b,a}, active-low; non-BCD nibbles show 'E'.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0000110;
    endcase
    return s;
  endfunction

  assign tick = (refresh_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_state  <= DIG0;
      shown       <= 12'h000;
      id          <= 1'b0;
    end else begin
      refresh_cnt <= tick ? '0 : refresh_cnt + CW'(1);
      scan_state  <= scan_state_nxt;
      if (load) begin
        shown <= show_second ? second_num : first_num;
        id    <= show_second;
      end
    end
  end

  always_comb begin
    scan_state_nxt = scan_state;
    if (tick) begin
      case (scan_state)
        DIG0:    scan_state_nxt = DIG1;
        DIG1:    scan_state_nxt = DIG2;
        DIG2:    scan_state_nxt = DIG3;
        DIG3:    scan_state_nxt = DIG0;
        default: scan_state_nxt = DIG0;
      endcase
    end
  end

  logic blank_hund;
  logic blank_tens;

`ifdef LEADING_ZERO_BLANK_EN
  // Invalid nibbles are nonzero, so they never trigger blanking.
  assign blank_hund = (shown[11:8] == 4'd0);
  assign blank_tens = (shown[11:8] == 4'd0) && (shown[7:4] == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  always_comb begin
    an  = 4'b1111;
    seg = SEG_BLANK;
    case (scan_state)
      DIG0: begin
        an  = 4'b1110;
        seg = seg7(shown[3:0]);
      end
      DIG1: begin
        an  = 4'b1101;
        seg = blank_tens ? SEG_BLANK : seg7(shown[7:4]);
      end
      DIG2: begin
        an  = 4'b1011;
        seg = blank_hund ? SEG_BLANK : seg7(shown[11:8]);
      end
      DIG3: begin
        an  = 4'b0111;
        seg = id ? seg7(4'd2) : seg7(4'd1);
      end
      default: begin
        an  = 4'b1111;
        seg = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_module_display_mux.sv
// Bench for module_display_mux at REFRESH_DIV=4: table-driven scans, directed
// reset/hold/coincidence sequences, and random traffic against a cycle-count model.
module tb_module_display_mux;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] first_num = '0;
  logic [11:0] second_num = '0;
  logic        show_second = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;

  int tests = 0;
  int fails = 0;

  module_display_mux #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .first_num(first_num), .second_num(second_num),
    .show_second(show_second), .load(load), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Display position is purely a function of edges elapsed since reset.
  int          m_t = 0;
  logic [11:0] m_shown = '0;
  logic        m_id = 1'b0;
  logic [6:0]  enc [16];

  localparam logic [6:0] BLK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BLK;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  task automatic model_expect(output logic [3:0] ea, output logic [6:0] es);
    int d;
    logic [3:0] nib;
    d = (m_t / DIV) % 4;
    ea = ~(4'b0001 << d);
    if (d == 3) begin
      es = m_id ? enc[2] : enc[1];
    end else begin
      nib = m_shown[4*d +: 4];
      es = enc[nib];
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 2 && m_shown[11:8] == 4'd0) es = BLK;
      if (d == 1 && m_shown[11:4] == 8'd0) es = BLK;
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic l, input logic ss,
                       input logic [11:0] f, input logic [11:0] s);
    @(negedge clk);
    rst = r; load = l; show_second = ss; first_num = f; second_num = s;
    @(posedge clk);
    if (r) begin
      m_t = 0; m_shown = '0; m_id = 1'b0;
    end else begin
      m_t++;
      if (l) begin
        m_shown = ss ? s : f;
        m_id = ss;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, show_second, first_num, second_num);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es);
    tests++;
    if (an !== ea || seg !== es) begin
      fails++;
      $display("FAIL %s: an=%b seg=%b, expected an=%b seg=%b", name, an, seg, ea, es);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] ea;
    logic [6:0] es;
    model_expect(ea, es);
    check(name, ea, es);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [11:0]      num;
    logic             sel;
    logic [3:0][6:0]  exp;   // index = scan digit 0..3
  } vec_t;

  vec_t vecs [5];

  initial begin
    enc[0] = 7'b1000000; enc[1] = 7'b1111001; enc[2] = 7'b0100100; enc[3] = 7'b0110000;
    enc[4] = 7'b0011001; enc[5] = 7'b0010010; enc[6] = 7'b0000010; enc[7] = 7'b1111000;
    enc[8] = 7'b0000000; enc[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) enc[i] = 7'b0000110;

    vecs[0] = '{12'h123, 1'b0, {7'b1111001, 7'b1111001, 7'b0100100, 7'b0110000}};
    vecs[1] = '{12'h456, 1'b1, {7'b0100100, 7'b0011001, 7'b0010010, 7'b0000010}};
    vecs[2] = '{12'h00A, 1'b0, {7'b1111001, LZ, LZ, 7'b0000110}};
    vecs[3] = '{12'h9F0, 1'b1, {7'b0100100, 7'b0010000, 7'b0000110, 7'b1000000}};
    vecs[4] = '{12'h050, 1'b0, {7'b1111001, LZ, 7'b0010010, 7'b1000000}};

    // Reset case: 2 reset edges, DIG0 '0' for 4 samples, then DIG1.
    cycle(1'b1, 1'b1, 1'b1, 12'h999, 12'h888);
    cycle(1'b1, 1'b1, 1'b0, 12'h777, 12'h666);
    check("reset_state", 4'b1110, 7'b1000000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 12'h555, 12'h444);
      check("reset_hold", 4'b1110, 7'b1000000);
    end
    idle();
    check("reset_first_tick", 4'b1101, LZ);

    // Table: reset, load on the next edge, then walk one full scan.
    foreach (vecs[v]) begin
      logic [11:0] other;
      other = 12'($urandom);
      cycle(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
      if (vecs[v].sel) cycle(1'b0, 1'b1, 1'b1, other, vecs[v].num);
      else             cycle(1'b0, 1'b1, 1'b0, vecs[v].num, other);
      for (int c = 1; c <= 4*DIV; c++) begin
        int d;
        d = (c / DIV) % 4;
        check($sformatf("table%0d_dig%0d", v, d), ~(4'b0001 << d), vecs[v].exp[d]);
        idle();
      end
    end

    // Reset mid-scan during DIG2, then a clean scan of 0x000.
    cycle(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    cycle(1'b0, 1'b1, 1'b0, 12'h789, 12'h0);
    while (m_t < 2*DIV + 1) idle();
    check("midscan_dig2", 4'b1011, 7'b1111000);
    cycle(1'b1, 1'b0, 1'b0, 12'h789, 12'h0);
    check("midscan_reset", 4'b1110, 7'b1000000);
    for (int c = 0; c < 4*DIV; c++) begin
      idle();
      check_model("midscan_rescan");
    end

    // Hold without load: 0x321 stays despite first_num changing.
    cycle(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    cycle(1'b0, 1'b1, 1'b0, 12'h321, 12'h0);
    cycle(1'b0, 1'b0, 1'b0, 12'h999, 12'h999);
    while (m_t < DIV) idle();
    check("hold_tens", 4'b1101, 7'b0100100);
    while (m_t < 2*DIV) idle();
    check("hold_hund", 4'b1011, 7'b0110000);
    while (m_t < 4*DIV) idle();
    check("hold_units", 4'b1110, 7'b1111001);

    // Load coinciding with the DIG0->DIG1 tick shows new tens immediately.
    cycle(1'b1, 1'b0, 1'b0, 12'h0, 12'h0);
    while (m_t < DIV - 1) idle();
    cycle(1'b0, 1'b1, 1'b1, 12'h111, 12'h456);
    check("coincide_tens", 4'b1101, 7'b0010010);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(49) == 0), ($urandom_range(5) == 0), 1'($urandom),
            12'($urandom), 12'($urandom));
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/module_display_mux.md
MODULE_DISPLAY_MUX -- requirements
Module: module_display_mux

Interface
REQ-001 The block SHALL have a single clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter: REFRESH_DIV, 27000, number of clk cycles each digit stays lit; legal values are 2 or more.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 first_num  input  12  first operand, 3 BCD digits {hundreds,tens,units}.
REQ-006 second_num  input  12  second operand, same format.
REQ-007 show_second  input  1  selects the source for load: 0 = first_num, 1 = second_num.
REQ-008 load  input  1  one-cycle strobe that latches the selected operand.
REQ-009 an  output  4  digit enables, active-low, one-hot-zero.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-011 The block SHALL hold a 12-bit register `shown` and a 1-bit register `id`.
REQ-012 On an edge with load=1:
- `shown` SHALL take (show_second ? second_num : first_num).
- `id` SHALL take show_second.
REQ-013 When load=0, `shown` and `id` SHALL hold; input changes SHALL NOT affect the display.
REQ-014 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the tick.
REQ-015 A 2-bit scan state SHALL advance on each tick: DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0.
REQ-016 Scan state to digit mapping:
- DIG0 = units, shown[3:0].
- DIG1 = tens, shown[7:4].
- DIG2 = hundreds, shown[11:8].
- DIG3 = operand index.
REQ-017 an SHALL be 1110, 1101, 1011, 0111 in DIG0..DIG3 respectively.
REQ-018 an and seg SHALL be combinational from the registered scan state, `shown` and `id`. A load is therefore visible the cycle after its edge.
REQ-019 Digit encoding for values 0-9 SHALL be:
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
REQ-020 Any digit nibble of 0xA-0xF SHALL display 'E' (0000110).
REQ-021 DIG3 SHALL display '1' (1111001) when id=0 and '2' (0100100) when id=1.
REQ-022 If load and tick occur on the same edge, both SHALL take effect. The new digit SHALL show the newly loaded value.
REQ-023 Each digit SHALL be lit for exactly REFRESH_DIV cycles; a full scan SHALL take 4*REFRESH_DIV cycles.

Reset
REQ-024 When rst=1 at an edge, the following SHALL be cleared regardless of other inputs:
- `shown` = 0x000 and `id` = 0.
- Refresh counter = 0.
- Scan state = DIG0.
REQ-025 After reset, an SHALL be 1110 and seg SHALL be 1000000, holding until the first tick.
REQ-026 rst SHALL take priority over load.
REQ-027 Reset mid-scan SHALL abort the scan; the next edge yields the REQ-025 outputs.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-029 With LEADING_ZERO_BLANK_EN defined:
- The hundreds digit SHALL be blank (1111111) when shown[11:8]=0.
- The tens digit SHALL be blank when shown[11:8]=0 and shown[7:4]=0.
- The units digit and DIG3 SHALL never blank.
- An invalid nibble SHALL count as nonzero.
REQ-030 Without the macro, all digits SHALL display per REQ-019 to REQ-021, with zeros shown.

Verification (REFRESH_DIV=4)
REQ-031 Reset case: assert rst for 2 cycles, then release.
- an=1110 and seg=1000000 SHALL hold for 4 cycles.
- an SHALL then be 1101.
REQ-032 Load first operand: first_num=0x123, show_second=0, load pulse.
- The scan SHALL show an 1110/seg 0110000, then 1101/0100100, then 1011/1111001, then 0111/1111001.
- Each digit SHALL last 4 cycles.
REQ-033 Load second operand: second_num=0x456, show_second=1, load pulse.
- Units SHALL be 0000010, tens 0010010, hundreds 0011001, DIG3 0100100.
REQ-034 Invalid digit: first_num=0x00A, show_second=0, load.
- Units SHALL be 0000110.
- Tens and hundreds SHALL be 1111111 with the macro, and 1000000 without it.
REQ-035 Reset mid-scan: load 0x789, then assert rst during DIG2.
- The next edge SHALL give an=1110 and seg=1000000.
- A subsequent scan SHALL show 0x000.
REQ-036 Hold without load: load 0x321, then change first_num to 0x999 with load=0.
- The display SHALL still scan 1, 2, 3 across units, tens, hundreds.
- A load/tick coincidence SHALL show the new value on that tick's digit.
